jtag_reg_bridge: RTL and testbench



---
 rtl/jtag_reg_bridge.sv | 137 +++++++++++++
 tb/tb_jtag_reg_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_reg_bridge.sv
// Debug-module register access bridge onto the register file JTAG side-port, retrying writes that collide with core writes.
// Optional read-back verify of each landed write is compiled in with JTAG_REG_VERIFY_EN.
module jtag_reg_bridge #(
   parameter int unsigned MAX_RETRY = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [4:0]  req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        jtag_we_o,
   output logic [4:0]  jtag_addr_o,
   output logic [31:0] jtag_wdata_o,
   input  logic [31:0] jtag_rdata_i,
   input  logic        ex_we_i,
   input  logic [4:0]  ex_waddr_i,
   output logic        busy_o
);

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_W      = 32;
   localparam int unsigned CNT_W      = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RESP
`ifdef JTAG_REG_VERIFY_EN
      , S_VERIFY
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] retry_q;
   logic             collision;

   // Any enabled core write to a non-zero register wins the port and drops our write
   assign collision = ex_we_i && (ex_waddr_i != REG_ADDR_W'(0));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         retry_q      <= '0;
         req_ready_o  <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_err_o    <= 1'b0;
         rsp_rdata_o  <= '0;
         jtag_we_o    <= 1'b0;
         jtag_addr_o  <= '0;
         jtag_wdata_o <= '0;
         busy_o       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  jtag_addr_o  <= req_addr_i;
                  jtag_wdata_o <= req_wdata_i;
                  retry_q      <= '0;
                  req_ready_o  <= 1'b0;
                  busy_o       <= 1'b1;
                  if (!req_we_i) begin
                     state <= S_READ;
                  end else if (req_addr_i == REG_ADDR_W'(0)) begin
                     // x0 is hardwired, so the write completes without touching the port
                     state       <= S_RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b0;
                     rsp_rdata_o <= req_wdata_i;
                  end else begin
                     state     <= S_WRITE;
                     jtag_we_o <= 1'b1;
                  end
               end else begin
                  req_ready_o <= 1'b1;
               end
            end
            S_WRITE: begin
               if (collision) begin
                  if (retry_q != CNT_W'(MAX_RETRY)) begin
                     retry_q <= retry_q + CNT_W'(1);
                  end
                  if (retry_q >= CNT_W'(MAX_RETRY - 1)) begin
                     state       <= S_RESP;
                     jtag_we_o   <= 1'b0;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= jtag_wdata_o;
                  end
               end else begin
                  jtag_we_o <= 1'b0;
`ifdef JTAG_REG_VERIFY_EN
                  state <= S_VERIFY;
`else
                  state       <= S_RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= jtag_wdata_o;
`endif
               end
            end
`ifdef JTAG_REG_VERIFY_EN
            S_VERIFY: begin
               state       <= S_RESP;
               rsp_valid_o <= 1'b1;
               rsp_err_o   <= (jtag_rdata_i != jtag_wdata_o);
               rsp_rdata_o <= jtag_rdata_i;
            end
`endif
            S_READ: begin
               state       <= S_RESP;
               rsp_valid_o <= 1'b1;
               rsp_err_o   <= 1'b0;
               rsp_rdata_o <= REG_W'(jtag_rdata_i);
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  state       <= S_IDLE;
                  rsp_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  req_ready_o <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Self-checking bench for jtag_reg_bridge: transaction-level timing model plus a register file model.
// Honours JTAG_REG_VERIFY_EN for the extra write cycle.
module tb_jtag_reg_bridge;

   localparam int unsigned MAX_RETRY = 4;
`ifdef JTAG_REG_VERIFY_EN
   localparam int VER_CYC = 1;
`else
   localparam int VER_CYC = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [4:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        jtag_we;
   logic [4:0]  jtag_addr;
   logic [31:0] jtag_wdata;
   logic [31:0] jtag_rdata;
   logic        ex_we = 1'b0;
   logic [4:0]  ex_waddr = '0;
   logic [31:0] ex_wdata = '0;
   logic        busy;

   logic [31:0] regs [32] = '{default: '0};
   int          cyc = 0;

   jtag_reg_bridge #(.MAX_RETRY(MAX_RETRY)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .jtag_we_o(jtag_we), .jtag_addr_o(jtag_addr), .jtag_wdata_o(jtag_wdata), .jtag_rdata_i(jtag_rdata),
      .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file: core port has priority, a colliding JTAG write is dropped, x0 is hardwired
   assign jtag_rdata = (jtag_addr == 5'd0) ? 32'd0 : regs[jtag_addr];
   always @(posedge clk) begin
      if (ex_we && ex_waddr != 5'd0) regs[ex_waddr] <= ex_wdata;
      if (jtag_we && !(ex_we && ex_waddr != 5'd0) && jtag_addr != 5'd0) regs[jtag_addr] <= jtag_wdata;
   end

   // Expected per-cycle outputs, written only by the stimulus process
   logic        exp_ready, exp_busy, exp_we, exp_rsp_valid, exp_rsp_chk, exp_err;
   logic [4:0]  exp_addr;
   logic [31:0] exp_wdata, exp_rdata;
   bit          cmp_en = 1'b0;

   typedef struct {
      string       nm;
      logic [31:0] act;
      logic [31:0] exp_v;
   } lit_t;
   lit_t lit_q[$];

   int checks = 0;
   int errors = 0;
   int lit_rd = 0;
   int we_cnt = 0;
   int rise_cnt = 0;
   int rise_cyc = 0;
   logic [31:0] rise_data = '0;
   logic        rise_err = 1'b0;
   logic        prev_valid = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp_v, $time);
      end
   endtask

   // Single compare process: model outputs every cycle, then pending literal pins
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("req_ready_o", 32'(req_ready), 32'(exp_ready));
         chk("busy_o", 32'(busy), 32'(exp_busy));
         chk("jtag_we_o", 32'(jtag_we), 32'(exp_we));
         chk("jtag_addr_o", 32'(jtag_addr), 32'(exp_addr));
         chk("jtag_wdata_o", jtag_wdata, exp_wdata);
         chk("rsp_valid_o", 32'(rsp_valid), 32'(exp_rsp_valid));
         if (exp_rsp_chk) begin
            chk("rsp_rdata_o", rsp_rdata, exp_rdata);
            chk("rsp_err_o", 32'(rsp_err), 32'(exp_err));
         end
         if (jtag_we === 1'b1) we_cnt++;
         if (rsp_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt++;
            rise_cyc  = cyc;
            rise_data = rsp_rdata;
            rise_err  = rsp_err;
         end
         prev_valid = rsp_valid;
      end
      while (lit_rd < lit_q.size()) begin
         chk(lit_q[lit_rd].nm, lit_q[lit_rd].act, lit_q[lit_rd].exp_v);
         lit_rd++;
      end
   end

   bit rnd_ex = 1'b0;
   int acc_cyc, acc_we, acc_rise;

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      lit_t e;
      e.nm = nm; e.act = act; e.exp_v = exp_v;
      lit_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cycle(input logic r, input logic b, input logic w, input logic v);
      exp_ready = r; exp_busy = b; exp_we = w; exp_rsp_valid = v; exp_rsp_chk = v;
   endtask

   task automatic ex_rand();
      if (rnd_ex) begin
         ex_we = 1'($urandom % 2); ex_waddr = 5'($urandom); ex_wdata = $urandom;
      end else begin
         ex_we = 1'b0;
      end
   endtask

   // Requests presented while busy must be ignored
   task automatic garbage();
      req_valid = 1'($urandom % 2); req_we = 1'($urandom % 2);
      req_addr = 5'($urandom); req_wdata = $urandom; rsp_ready = 1'($urandom % 2);
   endtask

   task automatic ex_write_cycle(input bit collide, input logic [4:0] a);
      logic [4:0] ea;
      if (collide) begin
         do ea = 5'($urandom_range(1, 31)); while (ea == a);
         ex_we = 1'b1; ex_waddr = ea; ex_wdata = $urandom;
      end else begin
         ex_we = 1'($urandom % 2); ex_waddr = 5'd0; ex_wdata = $urandom;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0; rsp_ready = 1'($urandom % 2); ex_rand();
         set_cycle(1, 0, 0, 0); step();
      end
   endtask

   task automatic zero_cycle();
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_err = 1'b0;
      set_cycle(0, 0, 0, 0); exp_rsp_chk = 1'b1;
   endtask

   task automatic accept(input logic we, input logic [4:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      rsp_ready = 1'($urandom % 2); ex_rand();
      set_cycle(1, 0, 0, 0);
      acc_cyc = cyc; acc_we = we_cnt; acc_rise = rise_cnt;
      step();
      exp_addr = a; exp_wdata = d; exp_err = 1'b0;
   endtask

   task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] d, input int ncol, input int rdly);
      logic [31:0] old;
      bit ab;
      int w;
      accept(we, a, d);
      if (!we) begin
         garbage(); ex_we = 1'b0;
         exp_rdata = (a == 5'd0) ? 32'd0 : regs[a];
         set_cycle(0, 1, 0, 0); step();
      end else if (a != 5'd0) begin
         old = regs[a];
         ab  = (ncol >= int'(MAX_RETRY));
         w   = ab ? int'(MAX_RETRY) : ncol + 1;
         for (int k = 0; k < w; k++) begin
            garbage(); ex_write_cycle(k < ncol, a);
            set_cycle(0, 1, 1, 0); step();
         end
         ex_we = 1'b0;
         for (int k = 0; k < VER_CYC; k++) begin
            garbage(); set_cycle(0, 1, 0, 0); step();
         end
         exp_rdata = d; exp_err = ab;
         lit("reg_after_write", regs[a], ab ? old : d);
      end else begin
         exp_rdata = d;
      end
      ex_we = 1'b0;
      for (int k = 0; k <= rdly; k++) begin
         garbage(); rsp_ready = (k == rdly);
         set_cycle(0, 1, 0, 1); step();
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
   endtask

   initial begin
      // Reset: outputs all zero while held, ready one cycle after release
      step();
      cmp_en = 1'b1;
      zero_cycle(); step(); step();
      rst_i = 1'b0; step();
      idle_cycles(2);

      // Read x5 after preloading through the core port
      ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF;
      set_cycle(1, 0, 0, 0); step();
      ex_we = 1'b0;
      txn(1'b0, 5'd5, 32'h0, 0, 0);
      lit("read_x5_data", rise_data, 32'hDEADBEEF);
      lit("read_x5_err", 32'(rise_err), 32'd0);
      lit("read_x5_lat", 32'(rise_cyc - acc_cyc), 32'd2);
      lit("read_x5_pulses", 32'(rise_cnt - acc_rise), 32'd1);
      idle_cycles(1);

      txn(1'b1, 5'd7, 32'h12345678, 0, 0);
      lit("wr_x7_we_cycles", 32'(we_cnt - acc_we), 32'd1);
      lit("wr_x7_reg", regs[7], 32'h12345678);
      lit("wr_x7_lat", 32'(rise_cyc - acc_cyc), 32'(2 + VER_CYC));
      idle_cycles(1);

      txn(1'b1, 5'd7, 32'hA5A50003, 2, 1);
      lit("wr_col2_we_cycles", 32'(we_cnt - acc_we), 32'd3);
      lit("wr_col2_reg", regs[7], 32'hA5A50003);
      lit("wr_col2_lat", 32'(rise_cyc - acc_cyc), 32'(4 + VER_CYC));
      lit("wr_col2_err", 32'(rise_err), 32'd0);
      idle_cycles(1);

      txn(1'b1, 5'd7, 32'h0BADF00D, 99, 0);
      lit("wr_stuck_err", 32'(rise_err), 32'd1);
      lit("wr_stuck_lat", 32'(rise_cyc - acc_cyc), 32'd5);
      lit("wr_stuck_reg", regs[7], 32'hA5A50003);
      idle_cycles(1);

      txn(1'b1, 5'd0, 32'hCAFEF00D, 0, 0);
      lit("wr_x0_we_cycles", 32'(we_cnt - acc_we), 32'd0);
      lit("wr_x0_lat", 32'(rise_cyc - acc_cyc), 32'd1);
      txn(1'b0, 5'd0, 32'h0, 0, 0);
      lit("rd_x0_data", rise_data, 32'd0);

      // Reset while holding a response
      accept(1'b0, 5'd5, 32'h0);
      exp_rdata = regs[5];
      set_cycle(0, 1, 0, 0); step();
      for (int k = 0; k < 3; k++) begin
         rsp_ready = 1'b0; rst_i = (k == 2);
         set_cycle(0, 1, 0, 1); step();
      end
      rst_i = 1'b0; zero_cycle(); step();
      set_cycle(1, 0, 0, 0);
      lit("ready_after_rst", 32'(req_ready), 32'd1);
      idle_cycles(1);

      // Reset in the middle of a colliding write: the write must not land
      accept(1'b1, 5'd12, 32'h77770012);
      begin
         logic [31:0] old12;
         old12 = regs[12];
         for (int k = 0; k < 3; k++) begin
            ex_write_cycle(1'b1, 5'd12); rst_i = (k == 2);
            set_cycle(0, 1, 1, 0); step();
         end
         rst_i = 1'b0; ex_we = 1'b0; zero_cycle(); step();
         lit("rst_write_reg", regs[12], old12);
      end
      idle_cycles(2);

      // Randomized traffic
      rnd_ex = 1'b1;
      for (int t = 0; t < 200; t++) begin
         txn(1'($urandom % 2), 5'($urandom % 32), $urandom, int'($urandom % 7), int'($urandom % 4));
         idle_cycles(int'($urandom % 3));
      end
      ex_we = 1'b0;
      idle_cycles(2);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
